// File: rtl/blackice_mx_reset_ctrl.sv
// blackice_mx_reset_ctrl: PLL-lock filtered, staged reset release with soft reset and sticky lock-loss flag
module blackice_mx_reset_ctrl #(
  parameter int LOCK_FILTER = 1024,
  parameter int STAGES = 2,
  parameter int STAGE_DELAY = 16,
  parameter int SW_HOLD = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pll_locked,
  input  logic              soft_reset_req,
  input  logic              lock_lost_clear,
  output logic [STAGES-1:0] reset_out,
  output logic              ready,
  output logic              lock_lost
);
  localparam int M1 = LOCK_FILTER > STAGE_DELAY ? LOCK_FILTER : STAGE_DELAY;
  localparam int MX = M1 > SW_HOLD ? M1 : SW_HOLD;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam int IW = STAGES > 1 ? $clog2(STAGES) : 1;
  localparam logic [CW-1:0] LF_END = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] SD_END = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] SH_END = CW'(SW_HOLD - 1);
  localparam logic [IW-1:0] IDX_END = IW'(STAGES - 1);
  typedef enum logic [2:0] {WAIT_LOCK, FILTER, RELEASE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [STAGES-1:0] rout_n;
  logic rdy_n, ll_n, lock_m, lock_s;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      state <= WAIT_LOCK;
      cnt <= '0;
      idx <= '0;
      reset_out <= '1;
      ready <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      reset_out <= rout_n;
      ready <= rdy_n;
      lock_lost <= ll_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    rout_n = reset_out;
    rdy_n = ready;
    ll_n = lock_lost & ~lock_lost_clear;
    case (state)
      WAIT_LOCK: begin
        rout_n = '1;
        rdy_n = 1'b0;
        cnt_n = '0;
        idx_n = '0;
        state_n = lock_s ? FILTER : WAIT_LOCK;
      end
      FILTER: begin
        state_n = !lock_s ? WAIT_LOCK : (cnt == LF_END) ? RELEASE : FILTER;
        cnt_n = (lock_s && cnt != LF_END) ? cnt + CW'(1) : '0;
        idx_n = '0;
      end
      default: begin
        // lock loss outranks everything else once filtering has completed
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          rout_n = '1;
          rdy_n = 1'b0;
          ll_n = 1'b1;
          cnt_n = '0;
          idx_n = '0;
        end else if (state == RELEASE) begin
          if (cnt == SD_END) begin
            rout_n[idx] = 1'b0;
            cnt_n = '0;
            idx_n = (idx == IDX_END) ? '0 : idx + IW'(1);
            state_n = (idx == IDX_END) ? RUN : RELEASE;
            rdy_n = (idx == IDX_END);
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else if (state == RUN) begin
          if (soft_reset_req) begin
            state_n = HOLD;
            rout_n = '1;
            rdy_n = 1'b0;
            cnt_n = '0;
          end
        end else begin
          state_n = (cnt == SH_END) ? RELEASE : HOLD;
          cnt_n = (cnt == SH_END) ? '0 : cnt + CW'(1);
          idx_n = '0;
        end
      end
    endcase
  end
endmodule
